// File: rtl/time_set_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_pkg
// Description : Shared types, field limits and wrap helper for the time-set
//               controller and its front-panel interface.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    localparam int HOURS_W   = 5;
    localparam int MIN_SEC_W = 6;

    localparam logic [HOURS_W-1:0]   HOURS_MAX   = 5'd23;
    localparam logic [MIN_SEC_W-1:0] MIN_SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    // Out-of-range values also wrap so a corrupt field recovers on one press.
    function automatic logic [MIN_SEC_W-1:0] wrap_inc(
        input logic [MIN_SEC_W-1:0] value,
        input logic [MIN_SEC_W-1:0] max
    );
        return (value >= max) ? '0 : value + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : time_set_controller_if
// Description : Front-panel bundle: buttons, 1 Hz tick, live time, shadow time,
//               counter control (load/hold) and display page/blank.
// Revision    : 1.0 - initial release
// ============================================================================
interface time_set_controller_if;
    import rtc_pkg::*;

    logic                 tick_1hz;
    logic                 btn_set;
    logic                 btn_inc;
    logic                 btn_page;
    logic [HOURS_W-1:0]   cur_hours;
    logic [MIN_SEC_W-1:0] cur_minutes;
    logic [MIN_SEC_W-1:0] cur_seconds;
    logic [HOURS_W-1:0]   set_hours;
    logic [MIN_SEC_W-1:0] set_minutes;
    logic [MIN_SEC_W-1:0] set_seconds;
    logic                 load;
    logic                 hold;
    logic                 mode;
    logic [3:0]           blank;

    modport master (
        input  tick_1hz, btn_set, btn_inc, btn_page,
        input  cur_hours, cur_minutes, cur_seconds,
        output set_hours, set_minutes, set_seconds,
        output load, hold, mode, blank
    );

    modport slave (
        output tick_1hz, btn_set, btn_inc, btn_page,
        output cur_hours, cur_minutes, cur_seconds,
        input  set_hours, set_minutes, set_seconds,
        input  load, hold, mode, blank
    );

endinterface
`default_nettype wire

// File: rtl/time_set_controller_btn_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge_sync
// Description : Two-flop synchroniser for an asynchronous button level followed
//               by a rising-edge detector (one-cycle pulse per press).
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge_sync (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic btn,
    output logic      rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/time_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : time_set_controller
// Description : Button-driven hh:mm:ss set sequence with blink mask, counter
//               hold/load and display paging. Optional macro
//               DISPLAY_AUTO_PAGE_EN adds timed page flipping in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_controller
    import rtc_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BLINK_HZ    = 2,
    parameter int AUTO_EXIT_S = 10,
    parameter int AUTO_PAGE_S = 5
) (
    input  wire logic             clk,
    input  wire logic             reset,
    time_set_controller_if.master bus
);

    localparam int c_half_period = CLK_HZ / (2 * BLINK_HZ);
    localparam int c_ph_w        = (c_half_period > 1) ? $clog2(c_half_period) : 1;
    localparam int c_idle_w      = $clog2(AUTO_EXIT_S + 1);

    logic [2:0] w_btn;
    logic [2:0] w_rise;
    logic       w_set_rise;
    logic       w_inc_rise;
    logic       w_page_rise;

    assign w_btn = {bus.btn_page, bus.btn_inc, bus.btn_set};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        btn_edge_sync u_sync (
            .clk   (clk),
            .reset (reset),
            .btn   (w_btn[gi]),
            .rise  (w_rise[gi])
        );
    end

    assign w_set_rise  = w_rise[0];
    assign w_inc_rise  = w_rise[1];
    assign w_page_rise = w_rise[2];

    state_t               r_state;
    logic [HOURS_W-1:0]   r_hours;
    logic [MIN_SEC_W-1:0] r_minutes;
    logic [MIN_SEC_W-1:0] r_seconds;
    logic [c_idle_w-1:0]  r_idle;
    logic [c_ph_w-1:0]    r_phase_cnt;
    logic                 r_ph;
    logic                 r_page;
    logic                 r_mode;
    logic [3:0]           r_blank;
    logic                 r_hold;
    logic                 r_load;

    state_t            w_next_state;
    logic              w_inc_ev;
    logic              w_timeout;
    logic              w_enter_set;
    logic [c_ph_w-1:0] w_next_phase_cnt;
    logic              w_next_ph;
    logic              w_page_toggle;
    logic              w_next_page;
    logic              w_next_mode;
    logic [3:0]        w_next_blank;

`ifdef DISPLAY_AUTO_PAGE_EN
    localparam int c_pg_w = (AUTO_PAGE_S > 1) ? $clog2(AUTO_PAGE_S) : 1;

    logic [c_pg_w-1:0] r_page_cnt;
    logic              w_page_auto;

    assign w_page_auto   = bus.tick_1hz && (r_page_cnt == c_pg_w'(AUTO_PAGE_S - 1));
    assign w_page_toggle = (r_state == RUN) && (w_page_rise || w_page_auto);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_page_cnt <= '0;
        end else if ((r_state != RUN) || w_page_rise || w_page_auto) begin
            r_page_cnt <= '0;
        end else if (bus.tick_1hz) begin
            r_page_cnt <= r_page_cnt + 1'b1;
        end
    end
`else
    localparam int c_unused_auto_page_s = AUTO_PAGE_S;

    assign w_page_toggle = (r_state == RUN) && w_page_rise;
`endif

    // Set beats inc; the timeout only fires on a cycle with no accepted edge.
    always_comb begin
        w_next_state = r_state;
        w_inc_ev     = w_inc_rise && !w_set_rise && (r_state != RUN);
        w_timeout    = (r_state != RUN) && !w_set_rise && !w_inc_ev && bus.tick_1hz &&
                       (r_idle == c_idle_w'(AUTO_EXIT_S - 1));
        case (r_state)
            RUN:     if (w_set_rise) w_next_state = SET_HR;
            SET_HR:  if (w_set_rise) w_next_state = SET_MIN;
            SET_MIN: if (w_set_rise) w_next_state = SET_SEC;
            SET_SEC: if (w_set_rise) w_next_state = RUN;
            default: w_next_state = RUN;
        endcase
        if (w_timeout) begin
            w_next_state = RUN;
        end
        w_enter_set = (w_next_state != RUN) && (w_next_state != r_state);

        w_next_phase_cnt = r_phase_cnt + 1'b1;
        w_next_ph        = r_ph;
        if ((w_next_state == RUN) || w_enter_set) begin
            w_next_phase_cnt = '0;
            w_next_ph        = 1'b0;
        end else if (r_phase_cnt == c_ph_w'(c_half_period - 1)) begin
            w_next_phase_cnt = '0;
            w_next_ph        = ~r_ph;
        end

        w_next_page = r_page ^ w_page_toggle;
        case (w_next_state)
            SET_HR:  begin w_next_mode = 1'b1;        w_next_blank = {w_next_ph, w_next_ph, 2'b00}; end
            SET_MIN: begin w_next_mode = 1'b0;        w_next_blank = {w_next_ph, w_next_ph, 2'b00}; end
            SET_SEC: begin w_next_mode = 1'b0;        w_next_blank = {2'b00, w_next_ph, w_next_ph}; end
            default: begin w_next_mode = w_next_page; w_next_blank = 4'b0000;                       end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RUN;
            r_hours     <= '0;
            r_minutes   <= '0;
            r_seconds   <= '0;
            r_idle      <= '0;
            r_phase_cnt <= '0;
            r_ph        <= 1'b0;
            r_page      <= 1'b0;
            r_mode      <= 1'b0;
            r_blank     <= 4'b0000;
            r_hold      <= 1'b0;
            r_load      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_phase_cnt <= w_next_phase_cnt;
            r_ph        <= w_next_ph;
            r_page      <= w_next_page;
            r_mode      <= w_next_mode;
            r_blank     <= w_next_blank;
            r_hold      <= (w_next_state != RUN);
            r_load      <= (r_state == SET_SEC) && w_set_rise;

            if ((w_next_state == RUN) || w_enter_set || w_set_rise || w_inc_ev) begin
                r_idle <= '0;
            end else if (bus.tick_1hz) begin
                r_idle <= r_idle + 1'b1;
            end

            if ((r_state == RUN) && w_set_rise) begin
                r_hours   <= bus.cur_hours;
                r_minutes <= bus.cur_minutes;
                r_seconds <= bus.cur_seconds;
            end else if (w_inc_ev) begin
                case (r_state)
                    SET_HR:  r_hours   <= HOURS_W'(wrap_inc(MIN_SEC_W'(r_hours), MIN_SEC_W'(HOURS_MAX)));
                    SET_MIN: r_minutes <= wrap_inc(r_minutes, MIN_SEC_MAX);
                    SET_SEC: r_seconds <= wrap_inc(r_seconds, MIN_SEC_MAX);
                    default: ;
                endcase
            end
        end
    end

    assign bus.set_hours   = r_hours;
    assign bus.set_minutes = r_minutes;
    assign bus.set_seconds = r_seconds;
    assign bus.load        = r_load;
    assign bus.hold        = r_hold;
    assign bus.mode        = r_mode;
    assign bus.blank       = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_time_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_set_controller
// Description : Directed bench for time_set_controller; commit strobes are
//               checked against a queue of expected shadow values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_controller;

    logic clk;
    logic reset;

    time_set_controller_if bus ();

    time_set_controller #(
        .CLK_HZ      (1000),
        .BLINK_HZ    (100),
        .AUTO_EXIT_S (3),
        .AUTO_PAGE_S (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int h;
        int m;
        int s;
        int mode;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit s, input bit i, input bit p);
        bus.btn_set  = s;
        bus.btn_inc  = i;
        bus.btn_page = p;
        repeat (4) step();
        bus.btn_set  = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_page = 1'b0;
        repeat (4) step();
    endtask

    task automatic pulse_tick();
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
        step();
    endtask

    task automatic check_set(input string name, input int h, input int m, input int s);
        check({name, "_hours"},   int'(bus.set_hours),   h);
        check({name, "_minutes"}, int'(bus.set_minutes), m);
        check({name, "_seconds"}, int'(bus.set_seconds), s);
    endtask

    // Scoreboard monitor: every load strobe must match the next queued commit.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.load) begin
                if (sb_q.size() == 0) begin
                    check("load_unexpected", int'(bus.load), 0);
                end else begin
                    e = sb_q.pop_front();
                    check("load_hours",   int'(bus.set_hours),   e.h);
                    check("load_minutes", int'(bus.set_minutes), e.m);
                    check("load_seconds", int'(bus.set_seconds), e.s);
                    check("load_hold",    int'(bus.hold),        0);
                    check("load_mode",    int'(bus.mode),        e.mode);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_ap;

        reset = 1'b0;
        repeat (3) begin
            bus.tick_1hz    = 1'($urandom);
            bus.btn_set     = 1'($urandom);
            bus.btn_inc     = 1'($urandom);
            bus.btn_page    = 1'($urandom);
            bus.cur_hours   = 5'($urandom);
            bus.cur_minutes = 6'($urandom);
            bus.cur_seconds = 6'($urandom);
            step();
        end
        check("rst_mode",  int'(bus.mode),  0);
        check("rst_blank", int'(bus.blank), 0);
        check("rst_hold",  int'(bus.hold),  0);
        check("rst_load",  int'(bus.load),  0);
        check_set("rst", 0, 0, 0);

        bus.tick_1hz = 1'b0;
        bus.btn_set  = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_page = 1'b0;
        bus.cur_hours = 5'd13; bus.cur_minutes = 6'd45; bus.cur_seconds = 6'd7;
        reset = 1'b1;
        repeat (2) step();

        press(0, 0, 1);
        check("page_run", int'(bus.mode), 1);

        // Entry into SET_HR, then watch the blink mask cycle by cycle.
        bus.btn_set = 1'b1;
        repeat (3) step();
        check("enter_hold",  int'(bus.hold),  1);
        check("enter_mode",  int'(bus.mode),  1);
        check("enter_blank", int'(bus.blank), 0);
        check_set("capture", 13, 45, 7);
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("blink_hr_k%0d", k), int'(bus.blank), ((k / 5) % 2 == 1) ? 4'b1100 : 4'b0000);
        end
        bus.btn_set = 1'b0;
        repeat (4) step();

        press(0, 1, 0);
        check("inc_hr", int'(bus.set_hours), 14);
        press(1, 0, 0);
        check("min_mode",  int'(bus.mode),  0);
        check("min_blank", int'(bus.blank), 4'b1100);
        press(0, 1, 0);
        press(0, 1, 0);
        check_set("inc_min", 14, 47, 7);
        press(1, 0, 0);
        sb_q.push_back('{h: 14, m: 47, s: 7, mode: 1});
        press(1, 0, 0);
        check("commit_hold", int'(bus.hold), 0);
        check("commit_load", int'(bus.load), 0);
        check("commit_mode", int'(bus.mode), 1);
        press(0, 0, 1);
        check("page_back", int'(bus.mode), 0);

        // Wrap boundaries, simultaneous set+inc, ignored page, then timeout.
        bus.cur_hours = 5'd23; bus.cur_minutes = 6'd59; bus.cur_seconds = 6'd58;
        press(1, 0, 0);
        check_set("capture2", 23, 59, 58);
        press(0, 1, 0);
        check("wrap_hr", int'(bus.set_hours), 0);
        press(1, 0, 0);
        press(0, 1, 0);
        check_set("wrap_min", 0, 0, 58);
        press(1, 1, 0);
        check("setinc_minutes", int'(bus.set_minutes), 0);
        check("sec_mode",       int'(bus.mode),        0);
        check("sec_blank",      int'(bus.blank),       4'b0011);
        press(0, 0, 1);
        check("sec_page_mode", int'(bus.mode), 0);
        press(0, 1, 0);
        check("inc_sec", int'(bus.set_seconds), 59);
        press(0, 1, 0);
        check_set("wrap_sec", 0, 0, 0);
        pulse_tick();
        pulse_tick();
        check("idle_hold2", int'(bus.hold), 1);
        pulse_tick();
        check("timeout_hold",  int'(bus.hold),  0);
        check("timeout_blank", int'(bus.blank), 0);
        check("timeout_mode",  int'(bus.mode),  0);
        repeat (3) step();

        // Reset mid-edit abandons the edit; inc in RUN is ignored.
        bus.cur_hours = 5'd5; bus.cur_minutes = 6'd6; bus.cur_seconds = 6'd7;
        press(1, 0, 0);
        check("edit_hold", int'(bus.hold), 1);
        reset = 1'b0;
        #1;
        check("midrst_hold", int'(bus.hold), 0);
        check_set("midrst", 0, 0, 0);
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();
        press(0, 1, 0);
        press(1, 0, 0);
        check_set("run_inc_ignored", 5, 6, 7);
        sb_q.push_back('{h: 5, m: 6, s: 7, mode: 0});
        press(1, 0, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        check("commit2_hold", int'(bus.hold), 0);

`ifdef DISPLAY_AUTO_PAGE_EN
        exp_ap = 1;
`else
        exp_ap = 0;
`endif
        pulse_tick();
        check("autopage_t1", int'(bus.mode), 0);
        pulse_tick();
        check("autopage_t2", int'(bus.mode), exp_ap);
        pulse_tick();
        pulse_tick();
        check("autopage_t4", int'(bus.mode), 0);

        repeat (4) step();
        check("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
